fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter PC_W, default 9, program-counter width in bits.
REQ-002 SHALL have parameter INS_W, default 32, instruction width in bits.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries, a power of two from 2 to 16.
REQ-004 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port redirect_valid  input  1  taken branch/jal/jalr; flush and refetch.
REQ-008 SHALL have port redirect_pc  input  PC_W  redirect target.
REQ-009 SHALL have port imem_req  output  1  fetch request valid.
REQ-010 SHALL have port imem_addr  output  PC_W  fetch address.
REQ-011 SHALL have port imem_gnt  input  1  memory accepts the request this cycle.
REQ-012 SHALL have port imem_rvalid  input  1  response valid; responses arrive in order, at least 1 cycle after grant.
REQ-013 SHALL have port imem_rdata  input  INS_W  response instruction.
REQ-014 SHALL have port out_valid  output  1  instruction available to the datapath.
REQ-015 SHALL have port out_ready  input  1  datapath consumes the instruction.
REQ-016 SHALL have port out_pc  output  PC_W  PC of out_instr.
REQ-017 SHALL have port out_instr  output  INS_W  instruction to decode.

Function
REQ-018 SHALL count a request as accepted only when imem_req and imem_gnt are both 1, then advance fetch_pc by 4 modulo 2^PC_W (508 wraps to 0 at PC_W=9).
REQ-019 SHALL assert imem_req only while occupancy plus outstanding is less than DEPTH, so that every response always has a slot; imem_addr SHALL equal fetch_pc.
REQ-020 SHALL tag each kept response with resp_pc, which advances by 4 for each kept response, and store {resp_pc, imem_rdata} at the queue tail.
REQ-021 SHALL pop the head when out_valid and out_ready are both 1; a push and a pop in the same cycle SHALL leave occupancy unchanged, including when the queue is full.
REQ-022 SHALL, on redirect_valid, empty the queue, set fetch_pc and resp_pc to redirect_pc with bits [1:0] forced to 0, and load the discard counter with the outstanding count, including any grant made that cycle.
REQ-023 SHALL force out_valid to 0 and imem_req to 0 in the redirect cycle; redirect SHALL take priority over push, pop and grant bookkeeping.
REQ-024 SHALL drop responses while the discard counter is non-zero, decrementing it once per drop; the queue SHALL never receive stale instructions.
REQ-025 SHALL NOT, without bypass, make a response visible on out_valid until the cycle after imem_rvalid.
REQ-026 SHALL hold out_valid, out_pc and out_instr stable while out_valid=1 and out_ready=0.

Reset
REQ-027 SHALL, while reset=1, drive imem_req=0 and out_valid=0, with queue empty, outstanding=0, discard=0, and fetch_pc=resp_pc=RESET_PC.
REQ-028 SHALL, on the first edge after reset deasserts, be able to raise imem_req with imem_addr=RESET_PC; reset asserted mid-transfer SHALL abandon all outstanding responses.

Configuration
REQ-029 SHALL, with macro FETCH_QUEUE_BYPASS_EN defined and the queue empty, present a kept response on out_valid/out_instr in the same cycle it arrives; if out_ready=1 that cycle, the response SHALL NOT be written.
REQ-030 SHALL, without FETCH_QUEUE_BYPASS_EN, always write a response into the queue first, giving a minimum rvalid-to-out_valid latency of 1 cycle.

Structure
REQ-031 SHALL place PC_W/INS_W defaults and typedef fetch_entry_t {pc, instr} in shared package fetch_pkg.
REQ-032 SHALL implement storage as one sub-module, fetch_fifo: circular buffer with read/write pointers and an occupancy counter.

Verification
REQ-033 SHALL cover reset release with gnt=1 and 1-cycle responses, out_ready=1: imem_addr sequence 0,4,8,...; out_pc 0,4,8 in order with matching out_instr.
REQ-034 SHALL cover out_ready=0 held 10 cycles: exactly DEPTH=4 outstanding+queued; imem_req drops to 0; out_pc=0 held stable; release yields 0,4,8,12 with no loss.
REQ-035 SHALL cover redirect to 0x40 with 2 requests outstanding: both responses dropped; next out_pc=0x40; no entry with pc<0x40 delivered.
REQ-036 SHALL cover redirect_pc=0x1FE: fetch address is 0x1FC, followed by 0x000 (wrap).
REQ-037 SHALL cover reset asserted mid-stream with 3 outstanding: outputs zero immediately; after release the first out_pc=RESET_PC; late responses from before reset are ignored.
REQ-038 SHALL cover bypass with an empty queue: with the macro, out_valid in the same cycle as rvalid; without it, out_valid one cycle later.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-path widths and the queue entry layout {pc, instr}.
package fetch_pkg;
  localparam int FETCH_PC_W  = 9;
  localparam int FETCH_INS_W = 32;
  localparam int PC_STEP     = 4;

  typedef struct packed {
    logic [FETCH_PC_W-1:0]  pc;
    logic [FETCH_INS_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer for tagged fetch entries; power-of-two DEPTH lets pointers wrap naturally.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 41,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // a full queue still accepts a write when the head leaves the same cycle
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr_ptr] <= wdata;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: sequential fetch, in-order response tagging, decode buffer.
// Define FETCH_QUEUE_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          PC_W     = FETCH_PC_W,
  parameter int          INS_W    = FETCH_INS_W,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [INS_W-1:0] imem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [INS_W-1:0] out_instr
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = PC_W + INS_W;

  logic [PC_W-1:0]  fetch_pc, resp_pc, redirect_aligned;
  logic [CW-1:0]    outstanding, discard, count, out_next;
  logic [CW:0]      inflight;
  logic [EW-1:0]    head;
  logic             empty, grant, keep, bypass, pop, push;

  assign redirect_aligned = redirect_pc & ~PC_W'(3);
  // every granted request must have a guaranteed slot when its response lands
  assign inflight  = {1'b0, count} + {1'b0, outstanding};
  assign imem_req  = !reset && !redirect_valid && (inflight < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;
  assign grant     = imem_req && imem_gnt;
  assign keep      = imem_rvalid && (discard == '0) && !redirect_valid && !reset;
  assign out_next  = outstanding + CW'(grant) - CW'(imem_rvalid);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = keep && empty;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = !reset && !redirect_valid && (!empty || bypass);
  assign {out_pc, out_instr} = bypass ? {resp_pc, imem_rdata} : head;
  assign pop  = out_valid && out_ready;
  assign push = keep && !(bypass && out_ready);

  fetch_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop && !bypass),
    .wdata ({resp_pc, imem_rdata}),
    .rdata (head),
    .count (count),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fetch_pc    <= PC_W'(RESET_PC);
      resp_pc     <= PC_W'(RESET_PC);
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_valid) begin
      // everything still in flight belongs to the old path
      fetch_pc    <= redirect_aligned;
      resp_pc     <= redirect_aligned;
      outstanding <= out_next;
      discard     <= out_next;
    end else begin
      if (grant) fetch_pc <= fetch_pc + PC_W'(PC_STEP);
      if (keep)  resp_pc  <= resp_pc + PC_W'(PC_STEP);
      outstanding <= out_next;
      if (imem_rvalid && discard != '0) discard <= discard - 1'b1;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order memory model, PC-stream scoreboard, directed scenarios.
`timescale 1ns/1ps
module tb_fetch_queue;
  import fetch_pkg::*;
  localparam int PC_W = 9, INS_W = 32, DEPTH = 4;
  localparam logic [PC_W-1:0] RST_PC = '0;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 0, reset = 1, redirect_valid = 0;
  logic [PC_W-1:0] redirect_pc = '0;
  logic imem_req, imem_gnt = 0, imem_rvalid = 0;
  logic [PC_W-1:0] imem_addr;
  logic [INS_W-1:0] imem_rdata = '0;
  logic out_valid, out_ready = 1;
  logic [PC_W-1:0] out_pc;
  logic [INS_W-1:0] out_instr;

  fetch_queue #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [INS_W-1:0] instr_of(input logic [PC_W-1:0] pc);
    return {16'hC0DE, 7'd0, pc};
  endfunction

  // memory: in-order responses, lat cycles after grant
  typedef struct { logic [PC_W-1:0] addr; int epoch; int due; } pend_t;
  pend_t pend[$];
  int cyc = 0, lat = 1;
  bit gnt_en = 1, gnt_pat = 0, rdy_pat = 0;

  always @(posedge clk) begin
    #1;
    cyc++;
    imem_gnt = gnt_en && !(gnt_pat && (cyc % 3 == 0));
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1; imem_rdata = instr_of(pend[0].addr);
    end else begin
      imem_rvalid = 0; imem_rdata = '0;
    end
    if (rdy_pat) out_ready = (cyc % 4 != 1);
  end

  // scoreboard: expected fetch/delivery PCs, modelled occupancy, stale tracking by epoch
  int epoch = 0, qcnt = 0;
  logic [PC_W-1:0] exp_fetch = RST_PC, exp_out = RST_PC;
  bit hold = 0;
  fetch_entry_t held;

  always @(negedge clk) begin : model
    int outst;
    bit kept;
    outst = pend.size();
    kept = 0;
    if (imem_rvalid && pend.size() > 0) begin
      kept = (pend[0].epoch == epoch);
      void'(pend.pop_front());
    end
    if (reset) begin
      chk("rst_req", imem_req, 0);
      chk("rst_valid", out_valid, 0);
      epoch++; qcnt = 0; exp_fetch = RST_PC; exp_out = RST_PC; hold = 0;
    end else if (redirect_valid) begin
      chk("redir_req", imem_req, 0);
      chk("redir_valid", out_valid, 0);
      epoch++; qcnt = 0; hold = 0;
      exp_fetch = redirect_pc & ~PC_W'(3);
      exp_out = exp_fetch;
    end else begin
      if (hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_pc", out_pc, held.pc);
        chk("hold_instr", out_instr, held.instr);
      end
      chk("out_valid", out_valid, 32'((qcnt > 0) || (BYP && kept)));
      if (out_valid) begin
        chk("out_pc", out_pc, exp_out);
        chk("out_instr", out_instr, instr_of(exp_out));
      end
      if (imem_req) begin
        chk("req_room", 32'((qcnt + outst) < DEPTH), 1);
        chk("imem_addr", imem_addr, exp_fetch);
      end
      hold = out_valid && !out_ready;
      held.pc = out_pc; held.instr = out_instr;
      if (out_valid && out_ready) exp_out += PC_W'(4);
      qcnt = qcnt + int'(kept) - int'(out_valid && out_ready);
      if (imem_req && imem_gnt) begin
        pend.push_back('{addr: imem_addr, epoch: epoch, due: cyc + lat});
        exp_fetch += PC_W'(4);
      end
    end
  end

  logic [PC_W-1:0] addr_q[$], pc_q[$];
  task automatic step(); @(posedge clk); #2; endtask
  task automatic run(input int n);
    addr_q.delete(); pc_q.delete();
    repeat (n) begin
      @(negedge clk);
      if (!reset && !redirect_valid) begin
        if (imem_req && imem_gnt) addr_q.push_back(imem_addr);
        if (out_valid && out_ready) pc_q.push_back(out_pc);
      end
    end
  endtask
  function automatic logic [31:0] at(input bit is_pc, input int i);
    if (is_pc) return (pc_q.size() > i) ? 32'(pc_q[i]) : 32'hDEAD;
    return (addr_q.size() > i) ? 32'(addr_q[i]) : 32'hDEAD;
  endfunction

  initial begin
    int g;
    // reset release with 1-cycle responses
    repeat (3) @(negedge clk);
    chk("t_rst_req", imem_req, 0);
    chk("t_rst_addr", imem_addr, 0);
    step(); reset = 0;
    run(8);
    chk("s1_addr0", at(0, 0), 0);  chk("s1_addr1", at(0, 1), 4);  chk("s1_addr2", at(0, 2), 8);
    chk("s1_pc0", at(1, 0), 0);    chk("s1_pc1", at(1, 1), 4);    chk("s1_pc2", at(1, 2), 8);

    // reset mid-stream with 3 outstanding
    step(); lat = 3;
    for (int i = 0; i < 30 && pend.size() != 3; i++) step();
    chk("s2_setup_pend", pend.size(), 3);
    reset = 1; out_ready = 0; lat = 1;
    #1;
    chk("s2_req_now", imem_req, 0);
    chk("s2_valid_now", out_valid, 0);
    repeat (5) step();
    reset = 0;
    // decode stalled: exactly DEPTH fetches then back-pressure
    g = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (imem_req && imem_gnt) g++;
      if (out_valid) chk("s2_pc_hold", out_pc, 0);
    end
    chk("s2_grants", g, DEPTH);
    chk("s2_req_low", imem_req, 0);
    chk("s2_valid_hi", out_valid, 1);
    step(); out_ready = 1;
    run(6);
    chk("s2_pc0", at(1, 0), 0);  chk("s2_pc1", at(1, 1), 4);
    chk("s2_pc2", at(1, 2), 8);  chk("s2_pc3", at(1, 3), 12);

    // redirect to 0x40 with two requests in flight
    gnt_en = 0; repeat (8) step();
    lat = 3; gnt_en = 1; step(); step(); gnt_en = 0; step();
    chk("s3_setup_pend", pend.size(), 2);
    redirect_valid = 1; redirect_pc = 9'h040; gnt_en = 1;
    @(negedge clk);
    chk("s3_req_redir", imem_req, 0);
    chk("s3_valid_redir", out_valid, 0);
    step(); redirect_valid = 0;
    run(12);
    chk("s3_addr0", at(0, 0), 9'h040);
    chk("s3_pc0", at(1, 0), 9'h040);
    chk("s3_pc1", at(1, 1), 9'h044);

    // misaligned redirect near the top of the address space
    lat = 1; step(); step();
    redirect_valid = 1; redirect_pc = 9'h1FE;
    step(); redirect_valid = 0;
    run(10);
    chk("s4_addr0", at(0, 0), 9'h1FC);  chk("s4_addr1", at(0, 1), 9'h000);
    chk("s4_pc0", at(1, 0), 9'h1FC);    chk("s4_pc1", at(1, 1), 9'h000);

    // single response into an empty queue
    gnt_en = 0; repeat (8) step();
    gnt_en = 1; step(); gnt_en = 0;
    @(negedge clk);
    chk("s5_grant", 32'(imem_req && imem_gnt), 1);
    @(negedge clk);
    chk("s5_same_cycle", out_valid, 32'(BYP));
    @(negedge clk);
    chk("s5_next_cycle", out_valid, 32'(!BYP));

    // irregular grant/ready pattern with a redirect in the middle
    step(); gnt_en = 1; gnt_pat = 1; rdy_pat = 1; lat = 2;
    repeat (30) step();
    redirect_valid = 1; redirect_pc = 9'h100;
    step(); redirect_valid = 0;
    repeat (30) step();
    rdy_pat = 0; out_ready = 1; gnt_pat = 0;
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish by 100000ns");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
